// File: rtl/regfile_writeback_unit.sv
// Register file write-port front end: merges ALU and LSU results and tracks pending writes.
// Optional LSU backpressure counter enabled by defining WB_STALL_CNT_EN.
module regfile_writeback_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned LSU_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic [31:0]     pending,
  output logic            reg_write,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     stall_count
);

  localparam int unsigned RD_W  = 5;
  localparam int unsigned NREG  = 32;
  localparam int unsigned PTR_W = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // LSU result FIFO storage and control
  logic [XLEN-1:0]  fifo_data [LSU_DEPTH];
  logic [RD_W-1:0]  fifo_rd   [LSU_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic full_c;
  logic empty_c;
  logic push_c;
  logic pop_c;

  assign full_c    = (count == CNT_W'(LSU_DEPTH));
  assign empty_c   = (count == CNT_W'(0));
  assign lsu_ready = !full_c;
  assign push_c    = lsu_valid && !full_c;
  // The ALU always owns the port when it has a result; buffered loads wait.
  assign pop_c     = !alu_valid && !empty_c;

  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_data[wr_ptr] <= lsu_data;
      fifo_rd[wr_ptr]   <= lsu_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Write-port source selection
  logic            sel_valid_c;
  logic [RD_W-1:0] sel_rd_c;
  logic [XLEN-1:0] sel_data_c;

  always_comb begin
    sel_valid_c = 1'b0;
    sel_rd_c    = '0;
    sel_data_c  = '0;
    if (alu_valid) begin
      sel_valid_c = 1'b1;
      sel_rd_c    = alu_rd;
      sel_data_c  = alu_data;
    end else if (!empty_c) begin
      sel_valid_c = 1'b1;
      sel_rd_c    = fifo_rd[rd_ptr];
      sel_data_c  = fifo_data[rd_ptr];
    end
  end

  // Registered write port; writes to x0 update address/data but never enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else if (sel_valid_c) begin
      reg_write  <= (sel_rd_c != RD_W'(0));
      rd         <= sel_rd_c;
      write_data <= sel_data_c;
    end else begin
      reg_write  <= 1'b0;
    end
  end

  // Scoreboard: a new issue outranks a retiring write to the same register.
  logic [NREG-1:0] pending_next_c;

  always_comb begin
    pending_next_c = pending;
    if (reg_write) begin
      pending_next_c[rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != RD_W'(0))) begin
      pending_next_c[issue_rd] = 1'b1;
    end
    pending_next_c[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next_c;
    end
  end

`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (lsu_valid && !lsu_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_count = stall_cnt;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: doc/regfile_writeback_unit.md
Name: regfile_writeback_unit

Overview:
- Write-side front end of the 32x32 register file. It merges results from the single-cycle ALU path and the long-latency load/store (LSU) path onto the register file's single write port (reg_write, rd, write_data).
- Keeps a pending-write scoreboard so decode can stall on RAW hazards against in-flight long-latency results.
- Sits between the execute/memory stages and the register file.

Parameters:
- XLEN, 32, data width of results and write_data.
- LSU_DEPTH, 4, entries in the LSU result FIFO; power of 2, minimum 2.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle; no backpressure, always accepted.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  LSU result accepted when lsu_valid && lsu_ready.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  XLEN  LSU result.
- issue_valid  in  1  a long-latency instruction issued this cycle.
- issue_rd  in  5  its destination; sets the scoreboard bit.
- pending  out  32  scoreboard; bit n=1 means a write to xn is outstanding.
- reg_write  out  1  register file write enable.
- rd  out  5  register file write address.
- write_data  out  XLEN  register file write data.
- stall_count  out  32  LSU backpressure cycle counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - reg_write=0, rd=0, write_data=0, pending=0.
  - FIFO empty, lsu_ready=1, stall_count=0.
  - Asserting reset mid-operation discards all buffered LSU results and clears the scoreboard immediately.
- LSU FIFO:
  - lsu_ready = !full, combinational from FIFO count only.
  - Push on lsu_valid && lsu_ready.
  - Pointers wrap modulo LSU_DEPTH.
  - Count width is clog2(LSU_DEPTH)+1.
  - Push and pop in the same cycle when full: push is refused, because lsu_ready was 0.
  - Push and pop in the same cycle when not full: count unchanged.
- Write-port arbitration (per cycle):
  - alu_valid=1: the ALU wins, FIFO does not pop.
  - alu_valid=0 and FIFO not empty: pop the FIFO head.
  - Otherwise: no write.
  - An LSU result pushed in cycle t can be popped at the earliest in cycle t+1; there is no same-cycle fall-through.
- Output register:
  - The selected result is registered. reg_write/rd/write_data are valid the cycle after selection, so ALU latency is exactly 1 cycle.
  - Selected rd=0: reg_write=0 for that cycle, with rd and write_data still updated. The write is dropped.
- Scoreboard:
  - Set: issue_valid && issue_rd!=0 sets pending[issue_rd] at the clock edge.
  - Clear: pending[rd] clears at the clock edge that ends a cycle with reg_write=1. This is the same edge the register file commits, so a read in the following cycle returns the new value.
  - Set and clear of the same register on the same edge: set wins, because it belongs to a newer instruction.
  - ALU writes also clear the bit; this is harmless since decode never issues to a pending register.
  - Re-issue to an already pending register leaves the bit at 1, with no counting.
  - pending[0] is constant 0.
- Ordering:
  - LSU results retire in arrival order.
  - ALU results may overtake buffered LSU results. Decode guarantees they target different registers via the scoreboard.

Optional Feature:
- Macro: WB_STALL_CNT_EN.
- Defined: stall_count increments by 1 on every cycle with lsu_valid && !lsu_ready. It saturates at 0xFFFFFFFF and resets to 0.
- Undefined: no counter logic; stall_count is tied to 0.

Test Plan:
- ALU latency: alu_valid=1, alu_rd=5, alu_data=0x1234 at cycle 0 -> cycle 1 shows reg_write=1, rd=5, write_data=0x1234. Cycle 2 shows reg_write=0 if no other source.
- x0 suppression: alu_rd=0, alu_data=0xFFFFFFFF -> reg_write stays 0. pending[0] stays 0 even with issue_valid=1, issue_rd=0.
- Arbitration and FIFO fill:
  - Stimulus: issue to x7..x10, push 4 LSU results while alu_valid=1 continuously.
  - Required: lsu_ready=0 after the 4th push; a 5th lsu_valid is held off. With WB_STALL_CNT_EN, stall_count increments each held cycle.
  - Then drop alu_valid: writes to x7,x8,x9,x10 appear on consecutive cycles in that order, and lsu_ready returns to 1 after the first pop.
- Scoreboard:
  - issue_rd=12 -> pending[12]=1 next cycle.
  - LSU result for x12 drains -> pending[12]=0 on the edge ending the reg_write=1 cycle.
  - Set of x12 on that same edge -> pending[12] remains 1.
- Async reset mid-operation: FIFO holding 3 entries and pending=0x00000F00, pull rst_n low between clock edges -> all outputs and pending read 0 immediately. After release, lsu_ready=1 and no stale writes appear.
